ni_axi_wr_ctrl: RTL and testbench
=================================

// Module: ni_axi_wr_ctrl
// PURPOSE
//  Write-channel controller of the NI AXI slave. Accepts AW/W from the PE and decodes
//  the destination router with axi_dec_noc. Sequences each burst into one NoC packet
//  (head flit + W beats) towards the packet generator. Bounds outstanding writes and
//  returns B responses in order. Sits between the AXI slave I/F and pkt gen.
// PARAMETERS
//  MAX_OT   default 4   max outstanding writes (AW accepted, B not yet handshaked); >=1
//  ID_W     default `AXI_TXN_ID_WIDTH   AWID/BID width
// PORTS
//  clk          in   1      clock; single clock domain
//  arst         in   1      reset, synchronous, active-high
//  aw_valid/aw_ready  in/out 1   AW handshake
//  aw_addr      in   `AXI_ADDR_WIDTH   burst address, decoded via axi_dec_noc
//  aw_id        in   ID_W   transaction ID
//  aw_len       in   8      beats-1 (AXI4)
//  w_valid/w_ready    in/out 1   W handshake
//  w_data       in   `AXI_DATA_WIDTH   write beat
//  w_last       in   1      last beat flag from master
//  b_valid/b_ready    out/in 1   B handshake
//  b_id         out  ID_W   response ID
//  b_resp       out  2      2'b00 OKAY, 2'b10 SLVERR
//  pkt_valid/pkt_ready out/in 1  flit handshake to pkt gen
//  pkt_head     out  1      flit is header
//  pkt_tail     out  1      flit is last of packet
//  pkt_data     out  `AXI_DATA_WIDTH   flit payload
//  ot_cnt       out  $clog2(MAX_OT+1)  current outstanding count
// BEHAVIOUR
//  Reset: FSM=IDLE, ot_cnt=0, B queue empty; aw_ready=w_ready=b_valid=pkt_valid=0,
//   pkt_head=pkt_tail=0, b_id=0, b_resp=0, pkt_data=0. arst mid-burst aborts: partial
//   packet lost, queued B responses dropped; no flit emitted in the reset cycle.
//  FSM IDLE: aw_ready = (ot_cnt<MAX_OT). On AW hs latch id,len,decode -> HEAD if
//   valid else DRAIN. beat_cnt<=0. w_ready=0.
//  HEAD: pkt_valid=1, pkt_head=1, pkt_tail=0, pkt_data={x_dest,y_dest,len,0-pad} MSB
//   first. Held stable until pkt_ready; then -> BODY. w_ready=0.
//  BODY: combinational pass-through: pkt_valid=w_valid, w_ready=pkt_ready,
//   pkt_data=w_data, pkt_head=0, pkt_tail=w_last|(beat_cnt==len). beat_cnt++ per hs.
//   On hs with pkt_tail: push {id, resp} to B queue; resp=OKAY iff w_last==(beat_cnt==len)
//   else SLVERR. If w_last arrived early -> IDLE; if beat_cnt==len but !w_last -> DRAIN
//   (resp already SLVERR, push deferred until w_last). Else -> IDLE.
//  DRAIN: w_ready=1, beats discarded, pkt_valid=0; on w_last hs push {id,SLVERR} -> IDLE.
//  Latency: AW hs -> head flit valid next cycle; body flits 0-cycle from W;
//   tail hs -> b_valid next cycle (queue registered).
//  B queue: depth MAX_OT, in-order; b_valid=!empty, b_id/b_resp from head; pop on hs.
//   Push and pop same cycle allowed (incl. empty pass takes 1 cycle). Cannot overflow
//   because AW gated by ot_cnt; overflow push is an assertion failure.
//  ot_cnt: +1 on AW hs, -1 on B hs, unchanged when both same cycle. Never wraps.
//  Only one burst sequenced at a time; a new AW accepted only in IDLE.
//  w_valid before AW (IDLE/HEAD) is not accepted (w_ready=0).
// STRUCTURE
//  ravenoc_pkg: s_noc_addr_t, noc_addr_map, axi_dec_noc(), e_wr_ctrl_st_t enum
//   {IDLE,HEAD,BODY,DRAIN}, AXI_OKAY/AXI_SLVERR constants, header field widths.
//  Sub-module: existing fifo (SLOTS=MAX_OT, WIDTH=ID_W+2) as B response queue.
//  SVA: pkt_data/valid stable while pkt_valid&!pkt_ready; ot_cnt<=MAX_OT.
// TESTING
//  1 AW addr in router(1,0) range, len=3, 4 W beats last on 4th, pkt_ready=1 ->
//    head {x=1,y=0,len=3}, 4 body flits tail on 4th, BID=aw_id, BRESP=00.
//  2 AW addr outside map, len=1 -> no pkt_valid, 2 beats drained, BRESP=10.
//  3 MAX_OT=4, b_ready=0, 5 single-beat bursts -> aw_ready low after 4th, ot_cnt=4;
//    one B hs -> ot_cnt=3, 5th AW accepted same cycle aw_ready rises.
//  4 len=3 but w_last on beat 2 -> tail on beat 2, BRESP=10, IDLE; len=1 w_last on
//    beat 3 -> tail on beat 2, beat 3 drained, BRESP=10.
//  5 pkt_ready toggling 1/0 per cycle during head+body -> flits unchanged while
//    stalled, W stalls in lockstep, ordering preserved.
//  6 arst asserted mid-BODY with 2 B pending -> next cycle all outputs at reset values,
//    ot_cnt=0, new burst completes normally.

Source files
------------

// File: rtl/ni_axi_wr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ni_axi_wr_ctrl_pkg
// Description : Shared types, constants and the AXI-address -> NoC-router
//               decoder used by the NI AXI write-channel controller.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_TXN_ID_WIDTH
`define AXI_TXN_ID_WIDTH 4
`endif

package ni_axi_wr_ctrl_pkg;

    localparam int ADDR_W = `AXI_ADDR_WIDTH;
    localparam int DATA_W = `AXI_DATA_WIDTH;

    // Header flit field widths: {x_dest, y_dest, len, zero pad}
    localparam int X_W   = 2;
    localparam int Y_W   = 2;
    localparam int LEN_W = 8;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    // 2x2 mesh, one 4 KiB window per router, row-major from NOC_BASE
    localparam int unsigned       NOC_X     = 2;
    localparam int unsigned       NOC_NODES = 4;
    localparam logic [ADDR_W-1:0] NOC_BASE  = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] NOC_SIZE  = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAD  = 2'd1,
        BODY  = 2'd2,
        DRAIN = 2'd3
    } e_wr_ctrl_st_t;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] size;
    } s_noc_addr_t;

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } s_noc_dest_t;

    // Address window and coordinates of router number idx
    function automatic s_noc_addr_t noc_addr_map(input int unsigned idx);
        s_noc_addr_t entry;
        entry.x    = X_W'(idx % NOC_X);
        entry.y    = Y_W'(idx / NOC_X);
        entry.base = NOC_BASE + ADDR_W'(idx) * NOC_SIZE;
        entry.size = NOC_SIZE;
        return entry;
    endfunction

    // Destination router of an AXI address; valid=0 when no window matches
    function automatic s_noc_dest_t axi_dec_noc(input logic [ADDR_W-1:0] addr);
        s_noc_dest_t dest;
        s_noc_addr_t entry;
        dest = '0;
        for (int unsigned i = 0; i < NOC_NODES; i++) begin
            entry = noc_addr_map(i);
            if ((addr >= entry.base) && (addr < (entry.base + entry.size))) begin
                dest.valid = 1'b1;
                dest.x     = entry.x;
                dest.y     = entry.y;
            end
        end
        return dest;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ni_axi_wr_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ni_axi_wr_ctrl_fifo
// Description : Small synchronous FIFO (registered storage, show-ahead read).
//               Output reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_axi_wr_ctrl_fifo #(
    parameter int SLOTS = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic [WIDTH-1:0] r_mem [SLOTS];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(SLOTS));
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));

endmodule

`default_nettype wire

// File: rtl/ni_axi_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ni_axi_wr_ctrl
// Description : NI AXI slave write-channel controller. Turns each AW/W burst
//               into one NoC packet (head flit + body beats), bounds the
//               number of outstanding writes and returns B in order.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_axi_wr_ctrl
    import ni_axi_wr_ctrl_pkg::*;
#(
    parameter int MAX_OT = 4,
    parameter int ID_W   = `AXI_TXN_ID_WIDTH
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [`AXI_ADDR_WIDTH-1:0]  aw_addr,
    input  logic [ID_W-1:0]             aw_id,
    input  logic [7:0]                  aw_len,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [`AXI_DATA_WIDTH-1:0]  w_data,
    input  logic                        w_last,
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic [ID_W-1:0]             b_id,
    output logic [1:0]                  b_resp,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic                        pkt_head,
    output logic                        pkt_tail,
    output logic [`AXI_DATA_WIDTH-1:0]  pkt_data,
    output logic [$clog2(MAX_OT+1)-1:0] ot_cnt
);

    localparam int OT_W     = $clog2(MAX_OT + 1);
    localparam int HEAD_PAD = DATA_W - X_W - Y_W - LEN_W;

    e_wr_ctrl_st_t    r_state;
    e_wr_ctrl_st_t    w_next_state;
    logic [ID_W-1:0]  r_id;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [OT_W-1:0]  r_ot_cnt;

    s_noc_dest_t      w_dec;
    logic             w_ot_ok;
    logic             w_aw_hs;
    logic             w_b_hs;
    logic             w_body_hs;
    logic             w_at_len;
    logic             w_push;
    logic [1:0]       w_push_resp;
    logic             w_q_empty;
    logic             w_q_full;
    logic [ID_W+1:0]  w_q_dout;

    assign w_dec     = axi_dec_noc(aw_addr);
    assign w_ot_ok   = (r_ot_cnt < OT_W'(MAX_OT));
    assign w_at_len  = (r_beat_cnt == r_len);
    assign w_aw_hs   = aw_valid & aw_ready;
    assign w_b_hs    = b_valid & b_ready;
    assign w_body_hs = (r_state == BODY) & w_valid & pkt_ready;
    assign ot_cnt    = r_ot_cnt;

    // B side is masked while reset is held so nothing is offered from a stale queue
    assign b_valid         = ~w_q_empty & ~arst;
    assign {b_id, b_resp}  = arst ? '0 : w_q_dout;

    // Next state and handshake outputs; all quiet while reset is held
    always_comb begin
        w_next_state = r_state;
        aw_ready     = 1'b0;
        w_ready      = 1'b0;
        pkt_valid    = 1'b0;
        pkt_head     = 1'b0;
        pkt_tail     = 1'b0;
        pkt_data     = '0;
        w_push       = 1'b0;
        w_push_resp  = AXI_OKAY;
        if (!arst) begin
            case (r_state)
                IDLE: begin
                    aw_ready = w_ot_ok;
                    if (aw_valid && w_ot_ok) begin
                        w_next_state = w_dec.valid ? HEAD : DRAIN;
                    end
                end
                HEAD: begin
                    pkt_valid = 1'b1;
                    pkt_head  = 1'b1;
                    pkt_data  = {r_x, r_y, r_len, {HEAD_PAD{1'b0}}};
                    if (pkt_ready) w_next_state = BODY;
                end
                BODY: begin
                    pkt_valid = w_valid;
                    w_ready   = pkt_ready;
                    pkt_data  = w_data;
                    pkt_tail  = w_last | w_at_len;
                    if (w_valid && pkt_ready && (w_last || w_at_len)) begin
                        if (w_last) begin
                            // Early w_last is a length mismatch as well
                            w_push       = 1'b1;
                            w_push_resp  = w_at_len ? AXI_OKAY : AXI_SLVERR;
                            w_next_state = IDLE;
                        end else begin
                            // Master sends more beats than announced: swallow them
                            w_next_state = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    w_ready = 1'b1;
                    if (w_valid && w_last) begin
                        w_push       = 1'b1;
                        w_push_resp  = AXI_SLVERR;
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (arst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Burst context captured at AW handshake, beat counter advanced per body flit
    always_ff @(posedge clk) begin
        if (arst) begin
            r_id       <= '0;
            r_len      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_beat_cnt <= '0;
        end else if (w_aw_hs) begin
            r_id       <= aw_id;
            r_len      <= aw_len;
            r_x        <= w_dec.x;
            r_y        <= w_dec.y;
            r_beat_cnt <= '0;
        end else if (w_body_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // Outstanding-write counter: AW in, B out
    always_ff @(posedge clk) begin
        if (arst) begin
            r_ot_cnt <= '0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_ot_cnt <= r_ot_cnt + 1'b1;
                2'b01:   r_ot_cnt <= r_ot_cnt - 1'b1;
                default: r_ot_cnt <= r_ot_cnt;
            endcase
        end
    end

    ni_axi_wr_ctrl_fifo #(
        .SLOTS (MAX_OT),
        .WIDTH (ID_W + 2)
    ) u_b_queue (
        .clk     (clk),
        .rst     (arst),
        .i_push  (w_push),
        .i_data  ({r_id, w_push_resp}),
        .i_pop   (w_b_hs),
        .o_data  (w_q_dout),
        .o_empty (w_q_empty),
        .o_full  (w_q_full)
    );

    a_pkt_stable: assert property (@(posedge clk) disable iff (arst)
        (pkt_valid && !pkt_ready) |=> (pkt_valid && $stable(pkt_data)));
    a_ot_bound: assert property (@(posedge clk) disable iff (arst)
        (r_ot_cnt <= OT_W'(MAX_OT)));
    a_q_no_overflow: assert property (@(posedge clk) disable iff (arst)
        !(w_push && w_q_full));

endmodule

`default_nettype wire

// File: tb/tb_ni_axi_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_axi_wr_ctrl
// Description : Directed self-checking bench for ni_axi_wr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_TXN_ID_WIDTH
`define AXI_TXN_ID_WIDTH 4
`endif

module tb_ni_axi_wr_ctrl;

    localparam int MAX_OT = 4;
    localparam int ID_W   = 4;

    logic        clk;
    logic        arst;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        pkt_valid, pkt_ready, pkt_head, pkt_tail;
    logic [31:0] pkt_data;
    logic [2:0]  ot_cnt;

    ni_axi_wr_ctrl #(.MAX_OT(MAX_OT), .ID_W(ID_W)) dut (
        .clk(clk), .arst(arst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_head(pkt_head), .pkt_tail(pkt_tail),
        .pkt_data(pkt_data), .ot_cnt(ot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fl(input logic h, input logic t, input logic [31:0] d);
        return {30'd0, h, t, d};
    endfunction

    function automatic logic [63:0] bv(input logic [3:0] id, input logic [1:0] resp);
        return {58'd0, id, resp};
    endfunction

    logic [63:0] flit_q[$];
    logic [63:0] b_q[$];
    logic [63:0] exp_f[$];
    logic [63:0] exp_b[$];

    bit          stall_chk = 1'b0;
    bit          toggle_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    // Records flit and B handshakes; checks stall stability when enabled
    always @(negedge clk) begin
        if (pkt_valid && pkt_ready) flit_q.push_back(fl(pkt_head, pkt_tail, pkt_data));
        if (b_valid && b_ready)     b_q.push_back(bv(b_id, b_resp));
        if (stall_chk) begin
            if (prev_stall) begin
                check_vec("stall_valid", pkt_valid, 1);
                check_vec("stall_data", pkt_data, prev_data);
            end
            if (pkt_valid && !pkt_head) check_vec("w_lockstep", w_ready, pkt_ready);
        end
        prev_stall = pkt_valid && !pkt_ready;
        prev_data  = pkt_data;
    end

    // Flit sink toggling its ready every cycle when enabled
    always begin
        @(posedge clk);
        if (toggle_en) begin
            #1 pkt_ready = ~pkt_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int t = 0;
        aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
        @(negedge clk);
        while (!aw_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!aw_ready) check_vec("aw_timeout", aw_ready, 1);
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic last);
        int t = 0;
        w_valid = 1'b1; w_data = data; w_last = last;
        @(negedge clk);
        while (!w_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!w_ready) check_vec("w_timeout", w_ready, 1);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        check_vec({tag, "_nflit"}, flit_q.size(), exp_f.size());
        for (int i = 0; i < exp_f.size() && i < flit_q.size(); i++)
            check_vec($sformatf("%s_flit%0d", tag, i), flit_q[i], exp_f[i]);
        check_vec({tag, "_nb"}, b_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < b_q.size(); i++)
            check_vec($sformatf("%s_b%0d", tag, i), b_q[i], exp_b[i]);
        flit_q.delete(); b_q.delete(); exp_f.delete(); exp_b.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_aw_ready"}, aw_ready, 0);
        check_vec({tag, "_w_ready"}, w_ready, 0);
        check_vec({tag, "_b_valid"}, b_valid, 0);
        check_vec({tag, "_pkt_valid"}, pkt_valid, 0);
        check_vec({tag, "_pkt_head"}, pkt_head, 0);
        check_vec({tag, "_pkt_tail"}, pkt_tail, 0);
        check_vec({tag, "_b_id"}, b_id, 0);
        check_vec({tag, "_b_resp"}, b_resp, 0);
        check_vec({tag, "_pkt_data"}, pkt_data, 0);
        check_vec({tag, "_ot_cnt"}, ot_cnt, 0);
    endtask

    initial begin
        arst = 1'b1; aw_valid = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0;
        w_valid = 1'b0; w_data = '0; w_last = 1'b0; b_ready = 1'b1; pkt_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_reset_outputs("rst0");
        tick();
        arst = 1'b0;
        tick();

        // 1: router(1,0), len=3, four beats
        aw_send(32'h1000_1000, 4'h3, 8'd3);
        @(negedge clk);
        check_vec("t1_head_valid", pkt_valid, 1);
        check_vec("t1_head_flag", pkt_head, 1);
        check_vec("t1_head_data", pkt_data, 32'h4030_0000);
        check_vec("t1_head_wready", w_ready, 0);
        tick();
        for (int i = 0; i < 4; i++) w_send(32'hA000_0000 + i, (i == 3));
        @(negedge clk);
        check_vec("t1_b_valid", b_valid, 1);
        check_vec("t1_b_id", b_id, 4'h3);
        check_vec("t1_b_resp", b_resp, 2'b00);
        tick(); repeat (3) tick();
        exp_f = '{fl(1, 0, 32'h4030_0000), fl(0, 0, 32'hA000_0000), fl(0, 0, 32'hA000_0001),
                  fl(0, 0, 32'hA000_0002), fl(0, 1, 32'hA000_0003)};
        exp_b = '{bv(4'h3, 2'b00)};
        compare_q("t1");

        // 2: unmapped address, both beats drained
        aw_send(32'h2000_0000, 4'h5, 8'd1);
        w_send(32'hB000_0000, 1'b0);
        w_send(32'hB000_0001, 1'b1);
        @(negedge clk);
        check_vec("t2_b_resp", b_resp, 2'b10);
        tick(); repeat (3) tick();
        exp_b = '{bv(4'h5, 2'b10)};
        compare_q("t2");

        // 3: outstanding limit with B held off
        b_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            aw_send(32'h1000_1000, 4'(i), 8'd0);
            w_send(32'hC000_0000 + i, 1'b1);
        end
        @(negedge clk);
        check_vec("t3_ot_full", ot_cnt, 4);
        check_vec("t3_aw_blocked", aw_ready, 0);
        tick();
        aw_valid = 1'b1; aw_addr = 32'h1000_1000; aw_id = 4'h5; aw_len = 8'd0;
        @(negedge clk);
        check_vec("t3_aw_still_blocked", aw_ready, 0);
        tick();
        b_ready = 1'b1;
        @(negedge clk);
        check_vec("t3_b_first_id", b_id, 4'h1);
        tick();
        b_ready = 1'b0;
        @(negedge clk);
        check_vec("t3_ot_after_b", ot_cnt, 3);
        check_vec("t3_aw_reopen", aw_ready, 1);
        tick();
        aw_valid = 1'b0;
        @(negedge clk);
        check_vec("t3_ot_refill", ot_cnt, 4);
        tick();
        w_send(32'hC000_0005, 1'b1);
        b_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check_vec("t3_ot_drained", ot_cnt, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            exp_f.push_back(fl(1, 0, 32'h4000_0000));
            exp_f.push_back(fl(0, 1, 32'hC000_0000 + i));
            exp_b.push_back(bv(4'(i), 2'b00));
        end
        compare_q("t3");

        // 4a: len=3, w_last early on beat 2
        aw_send(32'h1000_3000, 4'h6, 8'd3);
        w_send(32'hD000_0000, 1'b0);
        w_send(32'hD000_0001, 1'b1);
        @(negedge clk);
        check_vec("t4a_idle_aw_ready", aw_ready, 1);
        tick(); repeat (3) tick();
        exp_f = '{fl(1, 0, 32'h5030_0000), fl(0, 0, 32'hD000_0000), fl(0, 1, 32'hD000_0001)};
        exp_b = '{bv(4'h6, 2'b10)};
        compare_q("t4a");

        // 4b: len=1, w_last late on beat 3
        aw_send(32'h1000_2004, 4'h7, 8'd1);
        w_send(32'hE000_0000, 1'b0);
        w_send(32'hE000_0001, 1'b0);
        w_send(32'hE000_0002, 1'b1);
        repeat (4) tick();
        exp_f = '{fl(1, 0, 32'h1010_0000), fl(0, 0, 32'hE000_0000), fl(0, 1, 32'hE000_0001)};
        exp_b = '{bv(4'h7, 2'b10)};
        compare_q("t4b");

        // 5: flit sink toggling ready
        stall_chk = 1'b1;
        toggle_en = 1'b1;
        aw_send(32'h1000_0010, 4'h8, 8'd2);
        for (int i = 0; i < 3; i++) w_send(32'hF000_0000 + i, (i == 2));
        toggle_en = 1'b0;
        stall_chk = 1'b0;
        tick();
        pkt_ready = 1'b1;
        repeat (4) tick();
        exp_f = '{fl(1, 0, 32'h0020_0000), fl(0, 0, 32'hF000_0000), fl(0, 0, 32'hF000_0001),
                  fl(0, 1, 32'hF000_0002)};
        exp_b = '{bv(4'h8, 2'b00)};
        compare_q("t5");

        // 6: reset mid-body with two B responses pending
        b_ready = 1'b0;
        aw_send(32'h1000_1000, 4'h9, 8'd0);
        w_send(32'h1100_0000, 1'b1);
        aw_send(32'h1000_1000, 4'hA, 8'd0);
        w_send(32'h1100_0001, 1'b1);
        @(negedge clk);
        check_vec("t6_ot_pending", ot_cnt, 2);
        tick();
        aw_send(32'h1000_1000, 4'hB, 8'd3);
        w_send(32'h1200_0000, 1'b0);
        w_send(32'h1200_0001, 1'b0);
        w_valid = 1'b1; w_data = 32'h1200_0002; w_last = 1'b0; arst = 1'b1;
        @(negedge clk);
        check_vec("t6_rst_no_flit", pkt_valid, 0);
        check_vec("t6_rst_no_wready", w_ready, 0);
        tick();
        w_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        tick();
        arst = 1'b0;
        b_ready = 1'b1;
        flit_q.delete(); b_q.delete();
        aw_send(32'h1000_1000, 4'hC, 8'd0);
        w_send(32'h1300_0000, 1'b1);
        repeat (5) tick();
        @(negedge clk);
        check_vec("t6_ot_final", ot_cnt, 0);
        tick();
        exp_f = '{fl(1, 0, 32'h4000_0000), fl(0, 1, 32'h1300_0000)};
        exp_b = '{bv(4'hC, 2'b00)};
        compare_q("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
